alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared ALU16bit datapath. It accepts operand/opcode commands from requesters A and B over valid/ready handshakes and drives registered operands into the ALU. It captures the ALU result and error flag one cycle later and returns them, tagged with the requester id, over a valid/ready response port. It also keeps a saturating count of ALU errors.

---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter and sequencer in front of the shared ALU16bit
//   datapath. Two requesters (A, B) issue operand/opcode commands; the
//   granted command is registered onto alu_x/alu_y/alu_op, the ALU result
//   is captured one cycle later and returned on the response port, tagged
//   with the requester id. A saturating counter tracks ALU error responses.
//
// Handshake semantics (all three ports): a transfer happens on a rising
//   clock edge where valid && ready are both high. A producer holds its
//   valid and payload stable until it sees ready; ready never depends on
//   anything the producer changes in the same cycle other than valid.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   a_valid/a_ready/a_x/a_y/a_op   requester A command port
//   b_valid/b_ready/b_x/b_y/b_op   requester B command port
//   alu_x, alu_y, alu_op    registered operands/opcode to ALU16bit
//   alu_out, alu_rst        ALU16bit result and error flag (combinational)
//   rsp_valid/rsp_ready     response handshake
//   rsp_id, rsp_out, rsp_err  response payload (0 = A, 1 = B)
//   err_count               saturating count of error responses
//   busy                    high whenever the sequencer is not idle
//   dbg_state               current FSM state for debug/checkers
module alu_arbiter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [15:0]          a_x,
  input  logic [15:0]          a_y,
  input  logic [2:0]           a_op,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [15:0]          b_x,
  input  logic [15:0]          b_y,
  input  logic [2:0]           b_op,
  output logic [15:0]          alu_x,
  output logic [15:0]          alu_y,
  output logic [2:0]           alu_op,
  input  logic [16:0]          alu_out,
  input  logic                 alu_rst,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [16:0]          rsp_out,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic last_grant;  // 0 = A was granted last, 1 = B
  logic cur_id;      // id of the command currently in flight
  logic pick_b;      // arbitration choice if a grant happens this cycle
  logic grant;       // a command is accepted on the coming edge

  // Arbitration: a lone requester always wins; on a tie the requester
  // that was not granted last wins. Reset gates the grant so no ready is
  // shown while reset is held (state already reads IDLE during reset).
  always_comb begin
    pick_b = 1'b0;
    grant  = 1'b0;
    if (a_valid && b_valid) begin
      pick_b = ~last_grant;
    end else begin
      pick_b = b_valid;
    end
    grant = (state == IDLE) && !reset && (a_valid || b_valid);
  end

  assign a_ready   = grant && !pick_b;
  assign b_ready   = grant && pick_b;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. RESP always has rsp_valid high, so rsp_ready alone
  // decides when the response is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. alu_* only load on a grant, so they stay stable
  // through EXEC and RESP; rsp_* only load on the EXEC edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      alu_x      <= 16'd0;
      alu_y      <= 16'd0;
      alu_op     <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= 17'd0;
      rsp_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      if (grant) begin
        alu_x      <= pick_b ? b_x  : a_x;
        alu_y      <= pick_b ? b_y  : a_y;
        alu_op     <= pick_b ? b_op : a_op;
        cur_id     <= pick_b;
        last_grant <= pick_b;
      end
      if (state == EXEC) begin
        rsp_out   <= alu_out;
        rsp_err   <= alu_rst;
        rsp_id    <= cur_id;
        rsp_valid <= 1'b1;
        if (alu_rst && (err_count != {ERR_CNT_W{1'b1}})) begin
          err_count <= err_count + ERR_ONE;
        end
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A stand-in ALU16bit model drives
//   alu_out/alu_rst from the DUT's registered operands. A negedge monitor
//   keeps a transaction-level reference (one command in flight, round-robin
//   winner, response age, saturating error count) and a scoreboard queue of
//   expected responses; directed sequences add literal checks.
module tb_alu_arbiter;

  localparam int ERR_MAX = 255;

  logic        clock;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [15:0] a_x, a_y, b_x, b_y;
  logic [2:0]  a_op, b_op;
  logic [15:0] alu_x, alu_y;
  logic [2:0]  alu_op;
  logic [16:0] alu_out;
  logic        alu_rst;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [16:0] rsp_out;
  logic [7:0]  err_count;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [17:0] alu_res;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  alu_arbiter #(.ERR_CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_op(b_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_out(alu_out), .alu_rst(alu_rst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_err(rsp_err), .err_count(err_count),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Stand-in ALU16bit: returns {err, out[16:0]}.
  function automatic logic [17:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [2:0] op);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    case (op)
      3'd0:    alu_fn = {s[16], 1'b0, s[15:0]};
      3'd1:    alu_fn = {(x < y), 1'b0, x - y};
      3'd2:    alu_fn = {1'b0, 1'b0, x & y};
      3'd3:    alu_fn = {1'b0, 1'b0, x | y};
      3'd4:    alu_fn = {1'b0, 1'b0, x ^ y};
      3'd5:    alu_fn = {1'b0, 1'b0, ~x};
      3'd6:    alu_fn = {1'b0, x, 1'b0};
      default: alu_fn = {(x == y), 1'b1, x ^ y};
    endcase
  endfunction

  assign alu_res = alu_fn(alu_x, alu_y, alu_op);
  assign alu_out = alu_res[16:0];
  assign alu_rst = alu_res[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference monitor ----------------
  logic [18:0] exp_q[$];   // {id, out[16:0], err}
  logic        m_busy;     // a command is in flight
  logic        m_age;      // 0: next edge captures, 1: response visible
  logic        m_last;     // last granted id
  int          m_err;
  logic [15:0] m_x, m_y;
  logic [2:0]  m_op;

  initial begin
    m_busy = 1'b0; m_age = 1'b0; m_last = 1'b1; m_err = 0;
    m_x = 16'd0; m_y = 16'd0; m_op = 3'd0;
  end

  always @(negedge clock) begin
    logic        exp_any, exp_b;
    logic [18:0] e;
    logic [17:0] r;
    if (reset) begin
      chk("a_ready_in_reset", a_ready, 1'b0);
      chk("b_ready_in_reset", b_ready, 1'b0);
      chk("rsp_valid_in_reset", rsp_valid, 1'b0);
      chk("busy_in_reset", busy, 1'b0);
      chk("err_count_in_reset", err_count, 8'd0);
      exp_q.delete();
      m_busy = 1'b0; m_age = 1'b0; m_last = 1'b1; m_err = 0;
    end else begin
      exp_any = !m_busy && (a_valid || b_valid);
      exp_b   = (a_valid && b_valid) ? !m_last : b_valid;
      chk("a_ready", a_ready, exp_any && !exp_b);
      chk("b_ready", b_ready, exp_any && exp_b);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_age);
      chk("err_count", err_count, m_err);
      if (m_busy) begin
        chk("alu_x", alu_x, m_x);
        chk("alu_y", alu_y, m_y);
        chk("alu_op", alu_op, m_op);
        chk("exp_q_size", exp_q.size(), 1);
      end
      if (m_busy && m_age && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("rsp_id", rsp_id, e[18]);
        chk("rsp_out", rsp_out, e[17:1]);
        chk("rsp_err", rsp_err, e[0]);
      end
      // predict the coming edge
      if (m_busy) begin
        if (!m_age) begin
          m_age = 1'b1;
          if (exp_q.size() > 0 && exp_q[0][0] && m_err < ERR_MAX) m_err++;
        end else if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end else if (exp_any) begin
        m_x  = exp_b ? b_x  : a_x;
        m_y  = exp_b ? b_y  : a_y;
        m_op = exp_b ? b_op : a_op;
        r = alu_fn(m_x, m_y, m_op);
        exp_q.push_back({exp_b, r[16:0], r[17]});
        m_busy = 1'b1;
        m_age  = 1'b0;
        m_last = exp_b;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic a_hs, b_hs;
  int   cyc = 0;

  // One clock: sample handshakes at negedge, move to 1ns after posedge and
  // drop valid of any requester that was accepted.
  task automatic tick();
    @(negedge clock);
    a_hs = a_valid && a_ready;
    b_hs = b_valid && b_ready;
    @(posedge clock);
    #1;
    cyc++;
    if (a_hs) a_valid = 1'b0;
    if (b_hs) b_valid = 1'b0;
  endtask

  task automatic set_a(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
    a_valid = 1'b1; a_x = x; a_y = y; a_op = op;
  endtask

  task automatic set_b(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
    b_valid = 1'b1; b_x = x; b_y = y; b_op = op;
  endtask

  // Asserts reset between edges and checks outputs react immediately.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_out", rsp_out, 17'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_alu_x", alu_x, 16'd0);
    chk("rst_alu_y", alu_y, 16'd0);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_operand(output logic [15:0] v);
    if ($urandom_range(0, 3) == 0) v = 16'hFFFF;
    else v = 16'($urandom);
  endtask

  // ---------------- stimulus ----------------
  int grant_cyc[$];
  logic grant_id[$];

  initial begin
    logic [15:0] rx, ry;
    int waited;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_x = 16'd0; a_y = 16'd0; a_op = 3'd0;
    b_x = 16'd0; b_y = 16'd0; b_op = 3'd0;
    rsp_ready = 1'b1;
    a_hs = 1'b0; b_hs = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single add from A
    set_a(16'h00E1, 16'h0B01, 3'd0);
    tick();
    chk("add_a_hs", a_hs, 1'b1);
    chk("add_busy", busy, 1'b1);
    chk("add_rsp_valid_early", rsp_valid, 1'b0);
    tick();
    chk("add_rsp_valid", rsp_valid, 1'b1);
    chk("add_rsp_id", rsp_id, 1'b0);
    chk("add_rsp_out", rsp_out, 17'h00BE2);
    chk("add_rsp_err", rsp_err, 1'b0);
    tick();
    chk("add_done_valid", rsp_valid, 1'b0);

    // Subtract from B
    set_b(16'h0B01, 16'h00E1, 3'd1);
    tick();
    chk("sub_b_hs", b_hs, 1'b1);
    tick();
    chk("sub_rsp_id", rsp_id, 1'b1);
    chk("sub_rsp_out", rsp_out, 17'h00A20);
    chk("sub_rsp_err", rsp_err, 1'b0);
    tick();

    // Contention from reset
    a_valid = 1'b1; b_valid = 1'b1;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      if (!a_valid) set_a(16'($urandom), 16'($urandom), 3'd2);
      if (!b_valid) set_b(16'($urandom), 16'($urandom), 3'd4);
      tick();
      if (a_hs || b_hs) begin
        grant_cyc.push_back(cyc);
        grant_id.push_back(b_hs);
      end
    end
    chk("cont_grants", grant_cyc.size(), 5);
    for (int i = 0; i < 4 && i < grant_cyc.size(); i++) begin
      chk("cont_order", grant_id[i], i % 2);
      if (i > 0) chk("cont_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick(); tick();

    // Overflow and counter saturation
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      set_a(16'h0001, 16'hFFFF, 3'd0);
      tick();
      tick();
      if (i == 0) begin
        chk("ovf_rsp_out", rsp_out, 17'h00000);
        chk("ovf_rsp_err", rsp_err, 1'b1);
        chk("ovf_err_count_first", err_count, 8'd1);
      end
      tick();
    end
    chk("ovf_err_count_sat", err_count, 8'hFF);

    // Back-pressure while B waits
    set_a(16'h1234, 16'h0101, 3'd0);
    tick();
    chk("bp_a_hs", a_hs, 1'b1);
    set_b(16'h4444, 16'h0004, 3'd3);
    rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_out", rsp_out, 17'h01335);
      chk("bp_alu_x", alu_x, 16'h1234);
      chk("bp_b_hs", b_hs, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_b_hs", b_hs, 1'b0);
    chk("bp_release_valid", rsp_valid, 1'b0);
    tick();
    chk("bp_b_granted", b_hs, 1'b1);
    tick(); tick();

    // Reset during RESP
    set_a(16'h0F0F, 16'h0101, 3'd4);
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("mid_rsp_valid", rsp_valid, 1'b1);
    apply_reset();
    rsp_ready = 1'b1;
    set_a(16'h0003, 16'h0004, 3'd0);
    set_b(16'h0005, 16'h0006, 3'd1);
    tick();
    chk("post_rst_a_first", a_hs, 1'b1);
    chk("post_rst_b_wait", b_hs, 1'b0);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 2000; i++) begin
      if (!a_valid && $urandom_range(0, 99) < 60) begin
        rand_operand(rx); rand_operand(ry);
        set_a(rx, ry, 3'($urandom_range(0, 7)));
      end
      if (!b_valid && $urandom_range(0, 99) < 60) begin
        rand_operand(rx); rand_operand(ry);
        set_b(rx, ry, 3'($urandom_range(0, 7)));
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      tick();
    end

    // Drain outstanding work, bounded
    rsp_ready = 1'b1;
    waited = 0;
    while ((a_valid || b_valid || busy || exp_q.size() != 0) && waited < 200) begin
      tick();
      waited++;
    end
    chk("drain_timeout", (waited < 200), 1'b1);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
